mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous data/instruction memory between the CPU core (fetch/load/store, driven by the CPU control FSM) and one auxiliary master (I/O loader or display reader).
- Registered request/grant handshake with a fixed 2-cycle access slot per transfer.
- CPU has fixed priority; a wait counter prevents auxiliary starvation.
- Sits between the core's memory-bus mux and the memory block's port A.

---
 rtl/cpu_defs.sv | 19 +
 rtl/arb_starve_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared encodings and default widths for the memory port arbiter
package cpu_defs;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_CPU = 2'd1,
    ACC_AUX = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - counts denied aux cycles and forces an aux win at the limit
module arb_starve_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic aux_req,
  input  logic in_acc_aux,
  input  logic enter_aux,
  output logic force_aux
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  // Count cycles aux is waiting; restart when aux is served or stops asking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
    end else if (!aux_req || enter_aux) begin
      wait_cnt <= 8'd0;
    end else if (!in_acc_aux && (wait_cnt < MAX_CNT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign force_aux = aux_req && (wait_cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory port between the CPU and an aux master
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_WAIT  = 8,
  parameter int AUX_WRITE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state, next_state;
  owner_t            cap_owner;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] cpu_rdata_q, aux_rdata_q;
  logic              force_aux;
  logic              rd_done;

  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .aux_req   (aux_req),
    .in_acc_aux(state == ACC_AUX),
    .enter_aux (next_state == ACC_AUX),
    .force_aux (force_aux)
  );

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Arbitrate only when the port is free; an access slot always lasts ACC + DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (force_aux)     next_state = ACC_AUX;
        else if (cpu_req)  next_state = ACC_CPU;
        else if (aux_req)  next_state = ACC_AUX;
        else               next_state = IDLE;
      end
      ACC_CPU, ACC_AUX: next_state = DONE;
      default:          next_state = IDLE;
    endcase
  end

  // Capture the winner's command on the arbitration edge; aux writes become reads when disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_owner <= OWN_CPU;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (next_state == ACC_CPU) begin
      cap_owner <= OWN_CPU;
      cap_we    <= cpu_we;
      cap_addr  <= cpu_addr;
      cap_wdata <= cpu_wdata;
    end else if (next_state == ACC_AUX) begin
      cap_owner <= OWN_AUX;
      cap_we    <= (AUX_WRITE != 0) && aux_we;
      cap_addr  <= aux_addr;
      cap_wdata <= aux_wdata;
    end
  end

  // Keep each port's last read data so it holds while the other port is served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else if (rd_done) begin
      if (cap_owner == OWN_CPU) cpu_rdata_q <= mem_rdata;
      else                      aux_rdata_q <= mem_rdata;
    end
  end

  // Bus and handshake outputs decoded from the current slot phase
  always_comb begin
    rd_done    = (state == DONE) && !cap_we;
    cpu_gnt    = (state == ACC_CPU);
    aux_gnt    = (state == ACC_AUX);
    mem_we     = (cpu_gnt || aux_gnt) && cap_we;
    mem_addr   = cap_addr;
    mem_wdata  = cap_wdata;
    cpu_rvalid = rd_done && (cap_owner == OWN_CPU);
    aux_rvalid = rd_done && (cap_owner == OWN_AUX);
    cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    aux_rdata  = aux_rvalid ? mem_rdata : aux_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for the memory port arbiter
module tb_mem_port_arbiter;

  localparam int MW = 4;

  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } req_t;
  typedef struct { logic [15:0] data; int cyc; } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 0, cpu_we = 0, aux_req = 0, aux_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, aux_addr = 0, aux_wdata = 0;
  logic        cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid, mem_we;
  logic [15:0] cpu_rdata, aux_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 0;

  // second instance with aux writes disabled
  logic        c2_req = 0, c2_we = 0, a2_req = 0, a2_we = 0;
  logic [15:0] c2_addr = 0, c2_wdata = 0, a2_addr = 0, a2_wdata = 0;
  logic        c2_gnt, c2_rvalid, a2_gnt, a2_rvalid, mem_we2;
  logic [15:0] c2_rdata, a2_rdata, mem_addr2, mem_wdata2;
  logic [15:0] mem_rdata2 = 0;
  logic        mem2_wr_seen = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MW), .AUX_WRITE(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MW), .AUX_WRITE(0)) dut2 (
    .clk(clk), .rst(rst),
    .cpu_req(c2_req), .cpu_we(c2_we), .cpu_addr(c2_addr), .cpu_wdata(c2_wdata),
    .cpu_gnt(c2_gnt), .cpu_rvalid(c2_rvalid), .cpu_rdata(c2_rdata),
    .aux_req(a2_req), .aux_we(a2_we), .aux_addr(a2_addr), .aux_wdata(a2_wdata),
    .aux_gnt(a2_gnt), .aux_rvalid(a2_rvalid), .aux_rdata(a2_rdata),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(mem_rdata2));

  logic [15:0] mem    [0:255];
  logic [15:0] shadow [0:255];
  req_t cpu_q[$], aux_q[$];
  rd_t  cpu_rd_q[$], aux_rd_q[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, aux_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  always @(posedge clk) begin
    if (mem_we2) mem2_wr_seen <= 1'b1;
    mem_rdata2 <= mem_addr2 ^ 16'hA5A5;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic grant_check(input bit is_aux, input req_t e);
    string p;
    rd_t r;
    p = is_aux ? "aux" : "cpu";
    chk({p, "_gnt_addr"}, mem_addr, e.addr);
    chk({p, "_gnt_we"}, mem_we, e.we);
    if (e.we) begin
      chk({p, "_gnt_wdata"}, mem_wdata, e.wdata);
      shadow[e.addr[7:0]] = e.wdata;
    end else begin
      r.data = shadow[e.addr[7:0]];
      r.cyc  = cyc + 1;
      if (is_aux) aux_rd_q.push_back(r);
      else        cpu_rd_q.push_back(r);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a grant or read data
  always @(negedge clk) begin
    rd_t r;
    if (!rst) begin
      aux_wait = 0;
    end else begin
      if (!cpu_gnt && !aux_gnt) chk("idle_bus_we", mem_we, 0);
      if (cpu_gnt) chk("dual_gnt", aux_gnt, 0);
      if (cpu_gnt) begin
        if (cpu_q.size() == 0) chk("cpu_gnt_unexpected", cpu_gnt, 0);
        else grant_check(1'b0, cpu_q.pop_front());
      end
      if (aux_gnt) begin
        chk("aux_wait_bound", (aux_wait <= MW + 2), 1);
        aux_wait = 0;
        if (aux_q.size() == 0) chk("aux_gnt_unexpected", aux_gnt, 0);
        else grant_check(1'b1, aux_q.pop_front());
      end else if (aux_req) begin
        aux_wait++;
      end
      if (cpu_rvalid) begin
        if (cpu_rd_q.size() == 0) chk("cpu_rvalid_unexpected", cpu_rvalid, 0);
        else begin
          r = cpu_rd_q.pop_front();
          chk("cpu_rdata", cpu_rdata, r.data);
          chk("cpu_rvalid_cycle", cyc, r.cyc);
        end
      end
      if (aux_rvalid) begin
        if (aux_rd_q.size() == 0) chk("aux_rvalid_unexpected", aux_rvalid, 0);
        else begin
          r = aux_rd_q.pop_front();
          chk("aux_rdata", aux_rdata, r.data);
          chk("aux_rvalid_cycle", cyc, r.cyc);
        end
      end
      if (cpu_rd_q.size() > 0 && cpu_rd_q[0].cyc < cyc) begin
        chk("cpu_rvalid_missing", cpu_rvalid, 1);
        void'(cpu_rd_q.pop_front());
      end
      if (aux_rd_q.size() > 0 && aux_rd_q[0].cyc < cyc) begin
        chk("aux_rvalid_missing", aux_rvalid, 1);
        void'(aux_rd_q.pop_front());
      end
    end
  end

  task automatic cpu_xfer(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                          output int lat);
    req_t e;
    e.we = we; e.addr = addr; e.wdata = wd;
    cpu_q.push_back(e);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_gnt && lat < 100);
    if (!cpu_gnt) chk("cpu_gnt_timeout", cpu_gnt, 1);
    cpu_req = 1'b0;
  endtask

  task automatic aux_xfer(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                          output int lat);
    req_t e;
    e.we = we; e.addr = addr; e.wdata = wd;
    aux_q.push_back(e);
    aux_we = we; aux_addr = addr; aux_wdata = wd; aux_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!aux_gnt && lat < 100);
    if (!aux_gnt) chk("aux_gnt_timeout", aux_gnt, 1);
    aux_req = 1'b0;
  endtask

  initial begin
    int lat, l2, t0, n_cpu, k;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 16'($urandom);
      shadow[i] = mem[i];
    end
    mem[16'h0010] = 16'hBEEF;
    shadow[16'h0010] = 16'hBEEF;

    // reset state
    #3;
    chk("rst_outputs", {cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {cpu_rdata, aux_rdata}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // CPU-only read
    cpu_xfer(1'b0, 16'h0010, 16'h0, lat);
    chk("t1_gnt_latency", lat, 1);
    @(negedge clk);
    chk("t1_rdata", cpu_rdata, 16'hBEEF);
    @(negedge clk);

    // aux write then CPU read-back
    aux_xfer(1'b1, 16'h0020, 16'h1234, lat);
    chk("t2_gnt_latency", lat, 1);
    @(negedge clk);
    cpu_xfer(1'b0, 16'h0020, 16'h0, lat);
    @(negedge clk);
    chk("t2_readback", cpu_rdata, 16'h1234);

    // aux write on the read-only-aux instance
    a2_we = 1'b1; a2_addr = 16'h0020; a2_wdata = 16'h1234; a2_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!a2_gnt && k < 20);
    chk("aw0_gnt", a2_gnt, 1);
    chk("aw0_mem_we", mem_we2, 0);
    a2_req = 1'b0;
    @(negedge clk);
    chk("aw0_rvalid", a2_rvalid, 1);
    chk("aw0_rdata", a2_rdata, 16'h0020 ^ 16'hA5A5);
    chk("aw0_no_write", mem2_wr_seen, 0);
    repeat (2) @(negedge clk);

    // contention with both requests held
    fork
      begin
        for (int i = 0; i < 3; i++) cpu_xfer(1'b0, 16'(i + 3), 16'h0, l2);
      end
      aux_xfer(1'b0, 16'h0007, 16'h0, lat);
      begin
        t0 = cyc; n_cpu = 0; k = 0;
        do begin
          @(negedge clk); k++;
          if (cpu_gnt) n_cpu++;
        end while (!aux_gnt && k < 40);
        chk("t3_aux_gnt_cycle", cyc - t0, MW + 1);
        chk("t3_cpu_gnts_before", n_cpu, MW / 2);
        repeat (2) @(negedge clk);
        chk("t3_cpu_after_aux", cpu_gnt, 1);
      end
    join
    repeat (3) @(negedge clk);

    // back-to-back CPU reads
    cpu_xfer(1'b0, 16'h0001, 16'h0, lat);
    cpu_xfer(1'b0, 16'h0002, 16'h0, lat);
    chk("t4_b2b_spacing", lat, 2);
    repeat (3) @(negedge clk);

    // randomized traffic from both masters
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          cpu_xfer(1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom), l2);
        end
      end
      begin
        for (int j = 0; j < 60; j++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          aux_xfer(1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom), lat);
        end
      end
    join
    repeat (4) @(negedge clk);

    // reset during the ACC cycle of a CPU write
    cpu_xfer(1'b1, 16'h00F0, 16'hDEAD, lat);
    #1 rst = 1'b0;
    #1;
    chk("t5_async_we", mem_we, 0);
    chk("t5_async_gnt", cpu_gnt, 0);
    chk("t5_async_addr", mem_addr, 0);
    chk("t5_async_rdata", cpu_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_quiet", {cpu_rvalid, aux_rvalid, cpu_gnt, aux_gnt, mem_we}, 0);
    end
    chk("t5_hold_addr", mem_addr, 0);
    chk("t5_hold_wdata", mem_wdata, 0);
    cpu_xfer(1'b0, 16'h0030, 16'h0, lat);
    chk("t5_idle_after_release", lat, 1);
    repeat (3) @(negedge clk);

    chk("cpu_q_drained", cpu_q.size() + cpu_rd_q.size(), 0);
    chk("aux_q_drained", aux_q.size() + aux_rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
